// File: rtl/pll_reset_sequencer.sv
// Reset sequencer for an iCE40 PLL: pulses RESETB, waits for a stable lock, then
// releases the system reset. Runs on the reference clock so it survives PLL loss.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1200,
  parameter int LOCK_TIMEOUT   = 12000,
  parameter int PLL_RST_CYCLES = 12
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       locked,
  output logic       pll_resetb,
  output logic       reset_out,
  output logic       ready,
  output logic [7:0] relock_count,
  output logic [7:0] retry_count
);

  localparam int MAX_AB  = (STABLE_CYCLES > LOCK_TIMEOUT) ? STABLE_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX = (MAX_AB > PLL_RST_CYCLES) ? MAX_AB : PLL_RST_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [CNT_W-1:0]         cnt;
  logic                     cnt_inc;
  logic                     retry_hit;
  logic                     relock_hit;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     lock_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_inc    = 1'b0;
    retry_hit  = 1'b0;
    relock_hit = 1'b0;
    case (state)
      PLL_RST: begin
        if (cnt == RST_LAST) state_next = WAIT_LOCK;
        else                 cnt_inc    = 1'b1;
      end
      WAIT_LOCK: begin
        // A lock arriving on the timeout cycle takes priority over a retry.
        if (lock_s) begin
          state_next = STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          state_next = PLL_RST;
          retry_hit  = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s)                 state_next = WAIT_LOCK;
        else if (cnt == STABLE_LAST) state_next = RUN;
        else                         cnt_inc    = 1'b1;
      end
      RUN: begin
        // The PLL gets a fresh timeout to relock on its own before being reset.
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          relock_hit = 1'b1;
        end
      end
      default: state_next = PLL_RST;
    endcase
  end

  // Outputs decode the next state so they move on the same edge as the state.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state        <= PLL_RST;
      cnt          <= '0;
      pll_resetb   <= 1'b0;
      ready        <= 1'b0;
      reset_out    <= 1'b1;
      relock_count <= 8'd0;
      retry_count  <= 8'd0;
    end else begin
      state <= state_next;
      if (state_next != state) cnt <= '0;
      else if (cnt_inc)        cnt <= cnt + CNT_W'(1);

      pll_resetb <= (state_next != PLL_RST);
      ready      <= (state_next == RUN);
      reset_out  <= (state_next != RUN);

      if (retry_hit && retry_count != 8'hFF)   retry_count  <= retry_count + 8'd1;
      if (relock_hit && relock_count != 8'hFF) relock_count <= relock_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: phase/timestamp model compared every
// cycle, plus directed scenarios with hand-computed edge counts.
module tb_pll_reset_sequencer;

  localparam int SYNC = 2;
  localparam int STAB = 8;
  localparam int TMO  = 20;
  localparam int PRST = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       locked;
  logic       pll_resetb;
  logic       reset_out;
  logic       ready;
  logic [7:0] relock_count;
  logic [7:0] retry_count;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STAB),
    .LOCK_TIMEOUT  (TMO),
    .PLL_RST_CYCLES(PRST)
  ) dut (
    .clock_in    (clk),
    .reset       (reset),
    .locked      (locked),
    .pll_resetb  (pll_resetb),
    .reset_out   (reset_out),
    .ready       (ready),
    .relock_count(relock_count),
    .retry_count (retry_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: phase plus the edge it was entered on; lock seen by the sequencer is
  // simply the locked sample taken SYNC edges earlier.
  typedef enum {M_RST, M_WAIT, M_STAB, M_RUN} mphase_t;
  mphase_t m_phase;
  int      m_edge;
  int      m_enter;
  int      m_relock;
  int      m_retry;
  int      elapsed;
  bit      m_hist[$];
  bit      lock_used;

  function automatic void m_go(mphase_t p);
    m_phase = p;
    m_enter = m_edge;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase  = M_RST;
      m_edge   = 0;
      m_enter  = 0;
      m_relock = 0;
      m_retry  = 0;
      m_hist.delete();
      repeat (SYNC) m_hist.push_back(1'b0);
    end else begin
      m_edge++;
      lock_used = m_hist.pop_front();
      m_hist.push_back(locked);
      elapsed = m_edge - m_enter;
      case (m_phase)
        M_RST:  if (elapsed == PRST) m_go(M_WAIT);
        M_WAIT: begin
          if (lock_used) m_go(M_STAB);
          else if (elapsed == TMO) begin
            m_retry = (m_retry < 255) ? m_retry + 1 : 255;
            m_go(M_RST);
          end
        end
        M_STAB: begin
          if (!lock_used)            m_go(M_WAIT);
          else if (elapsed == STAB)  m_go(M_RUN);
        end
        M_RUN: begin
          if (!lock_used) begin
            m_relock = (m_relock < 255) ? m_relock + 1 : 255;
            m_go(M_WAIT);
          end
        end
        default: m_go(M_RST);
      endcase
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("cmp_pll_resetb", pll_resetb, m_phase != M_RST);
      check("cmp_ready", ready, m_phase == M_RUN);
      check("cmp_reset_out", reset_out, m_phase != M_RUN);
      check("cmp_relock_count", relock_count, m_relock);
      check("cmp_retry_count", retry_count, m_retry);
    end
  end

  function automatic logic sig(input int sel);
    return (sel == 0) ? pll_resetb : ready;
  endfunction

  // Counts edges (first upcoming posedge = 1) until the selected output equals val.
  task automatic wait_for(input int sel, input logic val, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (sig(sel) !== val && n < 300);
  endtask

  int n;

  initial begin
    reset  = 1'b1;
    locked = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pll_resetb", pll_resetb, 0);
    check("rst_reset_out", reset_out, 1);
    check("rst_ready", ready, 0);
    check("rst_relock", relock_count, 0);
    check("rst_retry", retry_count, 0);

    // Scenario 1: release reset with no lock.
    chk_en = 1'b1;
    reset  = 1'b0;
    wait_for(0, 1'b1, n);
    check("s1_pll_low_edges", n, 4);
    check("s1_reset_out", reset_out, 1);
    check("s1_ready", ready, 0);
    check("s1_retry", retry_count, 0);

    // Scenario 2: lock 3 cycles after pll_resetb rises.
    repeat (3) @(negedge clk);
    locked = 1'b1;
    wait_for(1, 1'b1, n);
    check("s2_ready_edges", n, 11);
    check("s2_reset_out", reset_out, 0);
    check("s2_relock", relock_count, 0);
    check("s2_retry", retry_count, 0);

    // Scenario 5: lock loss in RUN, then relock without a PLL reset.
    @(negedge clk);
    locked = 1'b0;
    wait_for(1, 1'b0, n);
    check("s5_loss_edges", n, 3);
    check("s5_reset_out", reset_out, 1);
    check("s5_relock", relock_count, 1);
    check("s5_pll_resetb", pll_resetb, 1);
    @(negedge clk);
    locked = 1'b1;
    wait_for(1, 1'b1, n);
    check("s5_relock_edges", n, 11);

    // Scenario 6: reset asserted between edges while in RUN.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("s6_reset_out", reset_out, 1);
    check("s6_ready", ready, 0);
    check("s6_pll_resetb", pll_resetb, 0);
    check("s6_relock", relock_count, 0);
    check("s6_retry", retry_count, 0);
    locked = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    wait_for(0, 1'b1, n);
    check("s6_pll_low_edges", n, 4);
    check("s6_ready_after", ready, 0);

    // Scenario 4: lock glitch of 3 cycles while in STABLE.
    @(negedge clk);
    locked = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    locked = 1'b0;
    repeat (3) @(negedge clk);
    locked = 1'b1;
    wait_for(1, 1'b1, n);
    check("s4_ready_edges", n, 11);
    check("s4_relock", relock_count, 0);

    // Scenario 3: never lock; retries saturate at 255.
    @(negedge clk);
    reset  = 1'b1;
    locked = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    wait_for(0, 1'b1, n);
    check("s3_first_low", n, 4);
    wait_for(0, 1'b0, n);
    check("s3_first_high", n, 20);
    check("s3_retry_one", retry_count, 1);
    for (int i = 0; i < 300; i++) begin
      wait_for(0, 1'b1, n);
      check("s3_low_len", n, 4);
      wait_for(0, 1'b0, n);
      check("s3_high_len", n, 20);
    end
    check("s3_retry_sat", retry_count, 255);
    check("s3_relock", relock_count, 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
